// File: rtl/cdc_dbg_pkg.sv
// Shared opcodes, response codes and FSM states for the USB CDC debug bridge.
package cdc_dbg_pkg;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] OP_PING  = 8'h03;

  localparam logic [7:0] RSP_WRITE   = 8'h81;
  localparam logic [7:0] RSP_READ    = 8'h82;
  localparam logic [7:0] RSP_PING    = 8'h83;
  localparam logic [7:0] RSP_TIMEOUT = 8'hE1;
  localparam logic [7:0] RSP_UNKNOWN = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_ADDR,
    ST_RX_DATA,
    ST_BUS,
    ST_TX
  } state_e;

endpackage

// File: rtl/cdc_dbg_tx.sv
// Response serializer: loads 1..5 bytes and shifts them out LSB byte first
// under a valid/ready handshake; done pulses while the last byte is taken.
module cdc_dbg_tx (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [2:0]  count_i,
  input  logic [39:0] payload_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        done_o
);

  logic [31:0] shift_q;
  logic [2:0]  remain_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        fire;

  assign fire = valid_q && ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      data_q   <= 8'h00;
      remain_q <= 3'd0;
    end else if (load_i) begin
      valid_q  <= 1'b1;
      data_q   <= payload_i[7:0];
      remain_q <= count_i;
    end else if (fire) begin
      if (remain_q == 3'd1) begin
        valid_q <= 1'b0;
      end else begin
        data_q <= shift_q[7:0];
      end
      remain_q <= remain_q - 3'd1;
    end
  end

  // Pending bytes only matter while valid is high, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (load_i) begin
      shift_q <= payload_i[39:8];
    end else if (fire) begin
      shift_q <= {8'h00, shift_q[31:8]};
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign done_o  = fire && (remain_q == 3'd1);

endmodule

// File: rtl/cdc_dbg_bridge.sv
// USB CDC byte-stream to 32-bit bus debug bridge: parses WRITE/READ/PING
// commands, runs one bus transaction with timeout, and serializes a response.
module cdc_dbg_bridge
  import cdc_dbg_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  out_data_i,
  input  logic        out_valid_i,
  output logic        out_ready_o,
  output logic [7:0]  in_data_o,
  output logic        in_valid_o,
  input  logic        in_ready_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q;
  logic [15:0] wait_cnt_q;
  logic        out_ready_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        out_fire;
  logic        byte_wrap;
  logic        ack_hit;
  logic        tmo_hit;
  logic        tx_load;
  logic [2:0]  tx_count;
  logic [39:0] tx_payload;
  logic        tx_done;

  assign out_fire  = out_valid_i && out_ready_q;
  assign byte_wrap = out_fire && (byte_cnt_q == 2'd3);
  assign ack_hit   = (state_q == ST_BUS) && bus_ack_i;
  // An ack in the final wait cycle takes priority over the timeout.
  assign tmo_hit   = (state_q == ST_BUS) && !bus_ack_i && (wait_cnt_q == TMO_LAST);

  always_comb begin
    state_d    = state_q;
    tx_load    = 1'b0;
    tx_count   = 3'd1;
    tx_payload = 40'h0;
    case (state_q)
      ST_IDLE: begin
        if (out_fire) begin
          if (out_data_i == OP_WRITE || out_data_i == OP_READ) begin
            state_d = ST_RX_ADDR;
          end else begin
            state_d    = ST_TX;
            tx_load    = 1'b1;
            tx_payload = {32'h0, (out_data_i == OP_PING) ? RSP_PING : RSP_UNKNOWN};
          end
        end
      end
      ST_RX_ADDR: begin
        if (byte_wrap) state_d = bus_we_q ? ST_RX_DATA : ST_BUS;
      end
      ST_RX_DATA: begin
        if (byte_wrap) state_d = ST_BUS;
      end
      ST_BUS: begin
        if (ack_hit) begin
          state_d = ST_TX;
          tx_load = 1'b1;
          if (bus_we_q) begin
            tx_payload = {32'h0, RSP_WRITE};
          end else begin
            tx_count   = 3'd5;
            tx_payload = {bus_rdata_i, RSP_READ};
          end
        end else if (tmo_hit) begin
          state_d    = ST_TX;
          tx_load    = 1'b1;
          tx_payload = {32'h0, RSP_TIMEOUT};
        end
      end
      ST_TX: begin
        if (tx_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers; out_ready and bus_req are registered from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      out_ready_q <= 1'b0;
      bus_req_q   <= 1'b0;
      byte_cnt_q  <= 2'd0;
      wait_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      out_ready_q <= (state_d inside {ST_IDLE, ST_RX_ADDR, ST_RX_DATA});
      bus_req_q   <= (state_d == ST_BUS);
      if ((state_q == ST_RX_ADDR || state_q == ST_RX_DATA) && out_fire) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
      end else if (state_q == ST_IDLE) begin
        byte_cnt_q <= 2'd0;
      end
      wait_cnt_q <= (state_q == ST_BUS && state_d == ST_BUS) ? wait_cnt_q + 16'd1 : 16'd0;
    end
  end

  // Command fields, assembled little-endian by shifting bytes in from the top.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus_we_q <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
    end else begin
      if (state_q == ST_IDLE && out_fire &&
          (out_data_i == OP_WRITE || out_data_i == OP_READ)) begin
        bus_we_q <= (out_data_i == OP_WRITE);
      end
      if (state_q == ST_RX_ADDR && out_fire) addr_q <= {out_data_i, addr_q[31:8]};
      if (state_q == ST_RX_DATA && out_fire) wdata_q <= {out_data_i, wdata_q[31:8]};
    end
  end

  cdc_dbg_tx u_tx (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (tx_load),
    .count_i   (tx_count),
    .payload_i (tx_payload),
    .data_o    (in_data_o),
    .valid_o   (in_valid_o),
    .ready_i   (in_ready_i),
    .done_o    (tx_done)
  );

  assign out_ready_o = out_ready_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;

endmodule
